core_req_bank_sel: RTL and testbench

Request-side counterpart of the cache core-response merge. Takes NUM_REQS parallel core word requests, decodes each request's bank from its word address, and arbitrates per bank with round-robin when several requests hit the same bank. Forwards one request per bank per cycle through a one-entry registered stage into the bank pipelines, and returns per-request ready to the core.

---
 rtl/core_req_bank_sel.sv | 162 ++++++++++++++++
 tb/tb_core_req_bank_sel.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/core_req_bank_sel.sv
// Request-side bank selector: decodes each core request's bank, picks one round-robin
// winner per bank and forwards it through a one-entry registered slot per bank.
module core_req_bank_sel #(
    parameter int NUM_REQS        = 4,
    parameter int NUM_BANKS       = 4,
    parameter int WORDS_PER_LINE  = 4,
    parameter int WORD_SIZE       = 4,
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int CORE_TAG_WIDTH  = 8,
    parameter int PERF_CTR_BITS   = 44,
    localparam int BSEL  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
    localparam int WSEL  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 0,
    localparam int WSELW = (WSEL > 0) ? WSEL : 1,
    localparam int LADDR = WORD_ADDR_WIDTH - BSEL - WSEL,
    localparam int RB    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQS-1:0]                    core_req_valid,
    input  logic [NUM_REQS-1:0]                    core_req_rw,
    input  logic [NUM_REQS*WORD_ADDR_WIDTH-1:0]    core_req_addr,
    input  logic [NUM_REQS*WORD_SIZE-1:0]          core_req_byteen,
    input  logic [NUM_REQS*8*WORD_SIZE-1:0]        core_req_data,
    input  logic [NUM_REQS*CORE_TAG_WIDTH-1:0]     core_req_tag,
    output logic [NUM_REQS-1:0]                    core_req_ready,
    output logic [NUM_BANKS-1:0]                   per_bank_req_valid,
    output logic [NUM_BANKS-1:0]                   per_bank_req_rw,
    output logic [NUM_BANKS*LADDR-1:0]             per_bank_req_addr,
    output logic [NUM_BANKS*WSELW-1:0]             per_bank_req_wsel,
    output logic [NUM_BANKS*WORD_SIZE-1:0]         per_bank_req_byteen,
    output logic [NUM_BANKS*8*WORD_SIZE-1:0]       per_bank_req_data,
    output logic [NUM_BANKS*RB-1:0]                per_bank_req_tid,
    output logic [NUM_BANKS*CORE_TAG_WIDTH-1:0]    per_bank_req_tag,
    input  logic [NUM_BANKS-1:0]                   per_bank_req_ready,
    output logic [PERF_CTR_BITS-1:0]               perf_bank_stalls
);
    localparam int BSELW = (BSEL > 0) ? BSEL : 1;
    localparam int DW    = 8 * WORD_SIZE;

    logic [BSELW-1:0]          req_bank_s   [NUM_REQS];
    logic [WSELW-1:0]          req_wsel_s   [NUM_REQS];
    logic [LADDR-1:0]          req_laddr_s  [NUM_REQS];
    logic [WORD_SIZE-1:0]      req_byteen_s [NUM_REQS];
    logic [DW-1:0]             req_data_s   [NUM_REQS];
    logic [CORE_TAG_WIDTH-1:0] req_tag_s    [NUM_REQS];

    logic [NUM_BANKS-1:0]      found_s;
    logic [RB-1:0]             winner_s     [NUM_BANKS];
    logic [NUM_BANKS-1:0]      can_accept_s;
    logic [NUM_BANKS-1:0]      accept_s;
    logic [PERF_CTR_BITS-1:0]  stall_cnt_s;

    logic [NUM_BANKS-1:0]      valid_r;
    logic [RB-1:0]             rr_ptr_r     [NUM_BANKS];
    logic [PERF_CTR_BITS-1:0]  perf_r;
    logic [NUM_BANKS-1:0]      rw_r;
    logic [LADDR-1:0]          laddr_r      [NUM_BANKS];
    logic [WSELW-1:0]          wsel_r       [NUM_BANKS];
    logic [WORD_SIZE-1:0]      byteen_r     [NUM_BANKS];
    logic [DW-1:0]             data_r       [NUM_BANKS];
    logic [RB-1:0]             tid_r        [NUM_BANKS];
    logic [CORE_TAG_WIDTH-1:0] tag_r        [NUM_BANKS];

    // Low address bits pick the word, the next ones the bank, the rest form the line address.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_dec
        assign req_laddr_s[i]  = core_req_addr[i*WORD_ADDR_WIDTH+WSEL+BSEL +: LADDR];
        assign req_byteen_s[i] = core_req_byteen[i*WORD_SIZE +: WORD_SIZE];
        assign req_data_s[i]   = core_req_data[i*DW +: DW];
        assign req_tag_s[i]    = core_req_tag[i*CORE_TAG_WIDTH +: CORE_TAG_WIDTH];
        if (WSEL > 0) begin : g_wsel
            assign req_wsel_s[i] = core_req_addr[i*WORD_ADDR_WIDTH +: WSELW];
        end else begin : g_nowsel
            assign req_wsel_s[i] = '0;
        end
        if (BSEL > 0) begin : g_bsel
            assign req_bank_s[i] = core_req_addr[i*WORD_ADDR_WIDTH+WSEL +: BSELW];
        end else begin : g_nobsel
            assign req_bank_s[i] = '0;
        end
    end

    // Per-bank round-robin: first valid candidate at or after the bank's pointer, with wrap.
    always_comb begin
        int   idx;
        logic cand;
        idx  = 0;
        cand = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            found_s[b]  = 1'b0;
            winner_s[b] = '0;
            for (int k = 0; k < NUM_REQS; k++) begin
                idx         = (int'(rr_ptr_r[b]) + k) % NUM_REQS;
                cand        = core_req_valid[idx] && (int'(req_bank_s[idx]) == b);
                winner_s[b] = (cand && !found_s[b]) ? RB'(idx) : winner_s[b];
                found_s[b]  = found_s[b] | cand;
            end
            can_accept_s[b] = !valid_r[b] || per_bank_req_ready[b];
            accept_s[b]     = found_s[b] && can_accept_s[b];
        end
    end

    // A request is ready only when it won its bank and that bank's slot can take it.
    always_comb begin
        core_req_ready = '0;
        stall_cnt_s    = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                core_req_ready[i] = core_req_ready[i] | (accept_s[b] && (int'(winner_s[b]) == i));
            end
            stall_cnt_s = stall_cnt_s + PERF_CTR_BITS'(core_req_valid[i] && !core_req_ready[i]);
        end
    end

    // Slot occupancy, round-robin pointers and the stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
            perf_r  <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_r[b] <= '0;
            end
        end else begin
            perf_r <= perf_r + stall_cnt_s;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (accept_s[b]) begin
                    valid_r[b]  <= 1'b1;
                    rr_ptr_r[b] <= RB'((int'(winner_s[b]) + 1) % NUM_REQS);
                end else if (per_bank_req_ready[b]) begin
                    valid_r[b] <= 1'b0;
                end
            end
        end
    end

    // Slot payload: loaded on accept, otherwise held; contents are meaningless while invalid.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (accept_s[b]) begin
                rw_r[b]     <= core_req_rw[winner_s[b]];
                laddr_r[b]  <= req_laddr_s[winner_s[b]];
                wsel_r[b]   <= req_wsel_s[winner_s[b]];
                byteen_r[b] <= req_byteen_s[winner_s[b]];
                data_r[b]   <= req_data_s[winner_s[b]];
                tid_r[b]    <= winner_s[b];
                tag_r[b]    <= req_tag_s[winner_s[b]];
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_out
        assign per_bank_req_rw[b]                                    = rw_r[b];
        assign per_bank_req_addr[b*LADDR +: LADDR]                   = laddr_r[b];
        assign per_bank_req_wsel[b*WSELW +: WSELW]                   = wsel_r[b];
        assign per_bank_req_byteen[b*WORD_SIZE +: WORD_SIZE]         = byteen_r[b];
        assign per_bank_req_data[b*DW +: DW]                         = data_r[b];
        assign per_bank_req_tid[b*RB +: RB]                          = tid_r[b];
        assign per_bank_req_tag[b*CORE_TAG_WIDTH +: CORE_TAG_WIDTH]  = tag_r[b];
    end
    assign per_bank_req_valid = valid_r;
    assign perf_bank_stalls   = perf_r;

endmodule

// File: tb/tb_core_req_bank_sel.sv
// Directed, table-driven bench for core_req_bank_sel with default parameters
// (4 requests, 4 banks, 4 words per line).
module tb_core_req_bank_sel;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   core_req_valid;
    logic [3:0]   core_req_rw;
    logic [119:0] core_req_addr;
    logic [15:0]  core_req_byteen;
    logic [127:0] core_req_data;
    logic [31:0]  core_req_tag;
    logic [3:0]   core_req_ready;
    logic [3:0]   per_bank_req_valid;
    logic [3:0]   per_bank_req_rw;
    logic [103:0] per_bank_req_addr;
    logic [7:0]   per_bank_req_wsel;
    logic [15:0]  per_bank_req_byteen;
    logic [127:0] per_bank_req_data;
    logic [7:0]   per_bank_req_tid;
    logic [31:0]  per_bank_req_tag;
    logic [3:0]   per_bank_req_ready;
    logic [43:0]  perf_bank_stalls;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    core_req_bank_sel dut (
        .clk                 (clk),
        .reset               (reset),
        .core_req_valid      (core_req_valid),
        .core_req_rw         (core_req_rw),
        .core_req_addr       (core_req_addr),
        .core_req_byteen     (core_req_byteen),
        .core_req_data       (core_req_data),
        .core_req_tag        (core_req_tag),
        .core_req_ready      (core_req_ready),
        .per_bank_req_valid  (per_bank_req_valid),
        .per_bank_req_rw     (per_bank_req_rw),
        .per_bank_req_addr   (per_bank_req_addr),
        .per_bank_req_wsel   (per_bank_req_wsel),
        .per_bank_req_byteen (per_bank_req_byteen),
        .per_bank_req_data   (per_bank_req_data),
        .per_bank_req_tid    (per_bank_req_tid),
        .per_bank_req_tag    (per_bank_req_tag),
        .per_bank_req_ready  (per_bank_req_ready),
        .perf_bank_stalls    (perf_bank_stalls)
    );

    typedef struct {
        logic [3:0]      vld;
        logic [3:0][7:0] addr;
        logic [3:0]      brdy;
        logic [3:0]      exp_rdy;
        logic [3:0]      exp_bvld;
        logic [3:0][1:0] exp_tid;
        logic [3:0][7:0] exp_line;
        logic [3:0][1:0] exp_wsel;
        logic [43:0]     exp_perf;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic [3:0] vld, input logic [31:0] addr, input logic [3:0] brdy,
                                input logic [3:0] erdy, input logic [3:0] ebvld, input logic [7:0] etid,
                                input logic [31:0] eline, input logic [7:0] ewsel, input int eperf);
        vec_t v;
        v.vld      = vld;
        v.addr     = addr;
        v.brdy     = brdy;
        v.exp_rdy  = erdy;
        v.exp_bvld = ebvld;
        v.exp_tid  = etid;
        v.exp_line = eline;
        v.exp_wsel = ewsel;
        v.exp_perf = 44'(eperf);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-request payload constants: tag A0+i, data D000_000i, byteen one-hot, rw = i[0].
    task automatic chk_bank(input string name, input int b, input logic [1:0] tid,
                            input logic [7:0] line, input logic [1:0] wsel);
        chk({name, " tid"},    64'(per_bank_req_tid[b*2 +: 2]),     64'(tid));
        chk({name, " line"},   64'(per_bank_req_addr[b*26 +: 26]),  64'(line));
        chk({name, " wsel"},   64'(per_bank_req_wsel[b*2 +: 2]),    64'(wsel));
        chk({name, " tag"},    64'(per_bank_req_tag[b*8 +: 8]),     64'(8'hA0 + 8'(tid)));
        chk({name, " data"},   64'(per_bank_req_data[b*32 +: 32]),  64'(32'hD000_0000 + 32'(tid)));
        chk({name, " byteen"}, 64'(per_bank_req_byteen[b*4 +: 4]),  64'(4'b0001 << tid));
        chk({name, " rw"},     64'(per_bank_req_rw[b]),             64'(tid[0]));
    endtask

    task automatic drive(input logic [3:0] vld, input logic [31:0] addr, input logic [3:0] brdy);
        core_req_valid     = vld;
        per_bank_req_ready = brdy;
        for (int i = 0; i < 4; i++) begin
            core_req_addr[i*30 +: 30] = {22'd0, addr[i*8 +: 8]};
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Rows run back to back; each row's expectations follow from the rows before it.
        tbl[0]  = mk(4'hF, 32'h10101010, 4'hF, 4'h1, 4'h0, 8'h00, 32'h00000000, 8'h00, 0);
        tbl[1]  = mk(4'hE, 32'h10101010, 4'hF, 4'h2, 4'h1, 8'h00, 32'h00000001, 8'h00, 3);
        tbl[2]  = mk(4'hC, 32'h10101010, 4'hF, 4'h4, 4'h1, 8'h01, 32'h00000001, 8'h00, 5);
        tbl[3]  = mk(4'h8, 32'h10101010, 4'hF, 4'h8, 4'h1, 8'h02, 32'h00000001, 8'h00, 6);
        tbl[4]  = mk(4'h0, 32'h10101010, 4'hF, 4'h0, 4'h1, 8'h03, 32'h00000001, 8'h00, 6);
        tbl[5]  = mk(4'hF, 32'h0C080400, 4'hF, 4'hF, 4'h0, 8'h00, 32'h00000000, 8'h00, 6);
        tbl[6]  = mk(4'h1, 32'h0000003F, 4'hF, 4'h1, 4'hF, 8'hE4, 32'h00000000, 8'h00, 6);
        tbl[7]  = mk(4'h1, 32'h00000004, 4'hF, 4'h1, 4'h8, 8'h00, 32'h03000000, 8'hC0, 6);
        tbl[8]  = mk(4'h3, 32'h00000814, 4'hD, 4'h2, 4'h2, 8'h00, 32'h00000000, 8'h00, 6);
        tbl[9]  = mk(4'h1, 32'h00000014, 4'hD, 4'h0, 4'h6, 8'h10, 32'h00000000, 8'h00, 7);
        tbl[10] = mk(4'h1, 32'h00000014, 4'hF, 4'h1, 4'h2, 8'h00, 32'h00000000, 8'h00, 8);
        tbl[11] = mk(4'h0, 32'h00000000, 4'hF, 4'h0, 4'h2, 8'h00, 32'h00000100, 8'h00, 8);
        tbl[12] = mk(4'h0, 32'h00000000, 4'hF, 4'h0, 4'h0, 8'h00, 32'h00000000, 8'h00, 8);

        reset           = 1'b1;
        core_req_rw     = 4'b1010;
        core_req_byteen = 16'h8421;
        core_req_data   = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        core_req_tag    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        core_req_addr   = '0;
        drive(4'h0, 32'h0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset bvld", 64'(per_bank_req_valid), 64'h0);
        chk("reset perf", 64'(perf_bank_stalls),   64'h0);
        chk("reset rdy",  64'(core_req_ready),     64'h0);
        next_cycle();

        for (int r = 0; r < 13; r++) begin
            drive(tbl[r].vld, tbl[r].addr, tbl[r].brdy);
            @(negedge clk);
            chk($sformatf("r%0d rdy", r),  64'(core_req_ready),     64'(tbl[r].exp_rdy));
            chk($sformatf("r%0d bvld", r), 64'(per_bank_req_valid), 64'(tbl[r].exp_bvld));
            chk($sformatf("r%0d perf", r), 64'(perf_bank_stalls),   64'(tbl[r].exp_perf));
            for (int b = 0; b < 4; b++) begin
                if (tbl[r].exp_bvld[b]) begin
                    chk_bank($sformatf("r%0d b%0d", r, b), b, tbl[r].exp_tid[b],
                             tbl[r].exp_line[b], tbl[r].exp_wsel[b]);
                end
            end
            next_cycle();
        end

        // Back-to-back stream into bank 0: one new line per cycle, no bubble.
        for (int c = 0; c < 10; c++) begin
            drive((c < 8) ? 4'h1 : 4'h0, {24'd0, 8'(c * 16)}, 4'hF);
            @(negedge clk);
            chk($sformatf("b2b%0d rdy", c),  64'(core_req_ready[0]),     64'(c < 8));
            chk($sformatf("b2b%0d bvld", c), 64'(per_bank_req_valid[0]), 64'(c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) begin
                chk_bank($sformatf("b2b%0d", c), 0, 2'd0, 8'(c - 1), 2'd0);
            end
            next_cycle();
        end
        chk("b2b perf", 64'(perf_bank_stalls), 64'd8);

        // Fill bank 2 while it is not ready, then reset over the held slot.
        drive(4'h1, 32'h00000008, 4'hB);
        @(negedge clk);
        chk("rst A rdy", 64'(core_req_ready), 64'h1);
        next_cycle();
        drive(4'h3, 32'h00000808, 4'hB);
        @(negedge clk);
        chk("rst B rdy",  64'(core_req_ready),     64'h0);
        chk("rst B bvld", 64'(per_bank_req_valid), 64'h4);
        chk_bank("rst B", 2, 2'd0, 8'd0, 2'd0);
        next_cycle();
        reset = 1'b1;
        drive(4'h0, 32'h0, 4'hB);
        @(negedge clk);
        chk("rst pre perf", 64'(perf_bank_stalls), 64'd10);
        next_cycle();
        reset = 1'b0;
        drive(4'hF, 32'h08080808, 4'hF);
        @(negedge clk);
        chk("rst post bvld", 64'(per_bank_req_valid), 64'h0);
        chk("rst post perf", 64'(perf_bank_stalls),   64'h0);
        chk("rst post rdy",  64'(core_req_ready),     64'h1);
        next_cycle();
        drive(4'h0, 32'h0, 4'hF);
        @(negedge clk);
        chk("rst rr bvld", 64'(per_bank_req_valid), 64'h4);
        chk_bank("rst rr", 2, 2'd0, 8'd0, 2'd0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
